// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver.
//
// Contents:
//   spi_state_e    - frame state encoding (IDLE / ACTIVE)
//   MODE00..MODE11 - SPI mode constants, packed as {CKP, CPH}
//   DEFAULT_WIDTH  - default word length in bits
//   spi_mode()     - packs CKP/CPH into a mode value
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // {CKP, CPH}
  localparam logic [1:0] MODE00 = 2'b00;
  localparam logic [1:0] MODE01 = 2'b01;
  localparam logic [1:0] MODE10 = 2'b10;
  localparam logic [1:0] MODE11 = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic logic [1:0] spi_mode(input logic ckp, input logic cph);
    return {ckp, cph};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection for one asynchronous input.
//
// Ports:
//   clk_i     - system clock
//   rst_ni    - synchronous, active-low reset
//   rst_val_i - value loaded into every stage on reset (the input's idle level)
//   d_i       - asynchronous input
//   q_o       - synchronized level
//   rise_o    - one-cycle strobe: synchronized level went 0 -> 1
//   fall_o    - one-cycle strobe: synchronized level went 1 -> 0
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting the previous copy to the idle level as well keeps reset release
  // from producing a spurious edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{rst_val_i}};
      prev_q <= rst_val_i;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    q_o    = sync_q[SYNC_STAGES-1];
    rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI slave receiver. Oversamples SCK/CS/MOSI in the clk domain, shifts MOSI in
// LSB-first and shifts a word preloaded at CS fall out on MISO. The shift
// register is a ring: after a full word it keeps shifting, so the received word
// is forwarded on MISO and slaves can be daisy-chained MISO -> MOSI.
//
// Ports:
//   clk, rst    - system clock, synchronous active-low reset
//   CKP, CPH    - SPI mode (idle polarity, sample phase); change only while idle
//   SCK, CS     - serial clock and active-low chip select (asynchronous)
//   MOSI        - serial data in (asynchronous)
//   data_in     - word returned to the master, captured at CS fall
//   MISO        - serial data out (0 while idle)
//   data_out    - last completed received word
//   data_valid  - one-cycle strobe, data_out updated
//   busy        - frame active
//   frame_err   - one-cycle strobe, CS rose with a partial word
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] data_in,
  output logic             MISO,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  // Synchronized inputs and edge strobes
  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sck (
    .clk_i    (clk),
    .rst_ni   (rst),
    .rst_val_i(CKP),
    .d_i      (SCK),
    .q_o      (sck_sync),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk_i    (clk),
    .rst_ni   (rst),
    .rst_val_i(1'b1),
    .d_i      (CS),
    .q_o      (cs_sync),
    .rise_o   (cs_rise),
    .fall_o   (cs_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_mosi (
    .clk_i    (clk),
    .rst_ni   (rst),
    .rst_val_i(1'b0),
    .d_i      (MOSI),
    .q_o      (mosi_sync),
    .rise_o   (mosi_rise),
    .fall_o   (mosi_fall)
  );

  // Only edges of SCK/CS and only the level of MOSI are needed.
  logic unused_sync;
  assign unused_sync = sck_sync ^ cs_sync ^ mosi_rise ^ mosi_fall;

  // Edge decode: leading edge leaves CKP, trailing edge returns to it. The
  // sample edge is leading for CPH=0 and trailing for CPH=1; MISO moves on the
  // opposite edge so it is stable half an SCK period before each sample.
  logic sample_edge, shift_edge;

  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    unique case (spi_mode(CKP, CPH))
      MODE00: begin sample_edge = sck_rise; shift_edge = sck_fall; end
      MODE01: begin sample_edge = sck_fall; shift_edge = sck_rise; end
      MODE10: begin sample_edge = sck_fall; shift_edge = sck_rise; end
      MODE11: begin sample_edge = sck_rise; shift_edge = sck_fall; end
      default: begin sample_edge = 1'b0; shift_edge = 1'b0; end
    endcase
  end

  // State and registered outputs
  spi_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic             miso_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             busy_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] shift_nxt;
  assign shift_nxt = {mosi_sync, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (cs_fall) begin
            shift_q <= data_in;
            miso_q  <= data_in[0];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          busy_q <= 1'b1;
          // CS release wins over a coincident sample edge; that bit is dropped.
          if (cs_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (cnt_q != '0) begin
              frame_err_q <= 1'b1;
            end
          end else begin
            if (sample_edge) begin
              shift_q <= shift_nxt;
              if (cnt_q == CntLast) begin
                // Word complete: no reload, the ring keeps forwarding bits.
                cnt_q        <= '0;
                data_out_q   <= shift_nxt;
                data_valid_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
            if (shift_edge) begin
              miso_q <= shift_q[0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO       = miso_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Bench for spi_slave_receiver: two slaves chained master -> A -> B -> master.
// Single-slave tests read A's MISO; B sees A's returned word on its MOSI.
module tb_spi_slave_receiver;

  localparam int HALF = 50;  // SCK half period in ns (5 clk periods)

  logic        clk = 1'b0;
  logic        rst, CKP, CPH, SCK, CS, MOSI;
  logic [15:0] data_in_a, data_in_b;
  logic        MISO_a, MISO_b;
  logic [15:0] data_out_a, data_out_b;
  logic        data_valid_a, data_valid_b, busy_a, busy_b, frame_err_a, frame_err_b;

  always #5 clk = ~clk;

  spi_slave_receiver #(.WIDTH(16), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS), .MOSI(MOSI),
    .data_in(data_in_a), .MISO(MISO_a), .data_out(data_out_a),
    .data_valid(data_valid_a), .busy(busy_a), .frame_err(frame_err_a)
  );

  spi_slave_receiver #(.WIDTH(16), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS), .MOSI(MISO_a),
    .data_in(data_in_b), .MISO(MISO_b), .data_out(data_out_b),
    .data_valid(data_valid_b), .busy(busy_b), .frame_err(frame_err_b)
  );

  // Monitor: records every data_valid word and every frame_err cycle.
  logic [15:0] got_a [64];
  logic [15:0] got_b [64];
  int n_got_a = 0, n_got_b = 0, ferr_a = 0, ferr_b = 0;

  always @(negedge clk) begin
    if (data_valid_a && n_got_a < 64) begin
      got_a[n_got_a] <= data_out_a;
      n_got_a        <= n_got_a + 1;
    end
    if (data_valid_b && n_got_b < 64) begin
      got_b[n_got_b] <= data_out_b;
      n_got_b        <= n_got_b + 1;
    end
    if (frame_err_a) ferr_a <= ferr_a + 1;
    if (frame_err_b) ferr_b <= ferr_b + 1;
  end

  int nchecks = 0, nerrors = 0;
  int rd_a = 0, rd_b = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Compare every expected word against what the monitor captured, then flag
  // any extra data_valid pulses.
  task automatic drain_one(input int s, input string name);
    logic [15:0] e;
    while ((s == 0 ? exp_a.size() : exp_b.size()) > 0) begin
      e = (s == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if (s == 0 && rd_a < n_got_a) begin
        check({name, " A data_out"}, 64'(got_a[rd_a]), 64'(e));
        rd_a++;
      end else if (s == 1 && rd_b < n_got_b) begin
        check({name, " B data_out"}, 64'(got_b[rd_b]), 64'(e));
        rd_b++;
      end else begin
        nchecks++;
        nerrors++;
        $display("FAIL %s slave %0d: no data_valid, expected data_out %0h", name, s, e);
      end
    end
    if (s == 0) begin
      check({name, " A extra valids"}, 64'(n_got_a - rd_a), 64'd0);
      rd_a = n_got_a;
    end else begin
      check({name, " B extra valids"}, 64'(n_got_b - rd_b), 64'd0);
      rd_b = n_got_b;
    end
  endtask

  task automatic drain(input string name);
    drain_one(0, name);
    drain_one(1, name);
  endtask

  task automatic set_mode(input logic ckp, input logic cph);
    CKP = ckp;
    CPH = cph;
    SCK = ckp;
    #(HALF * 2);
  endtask

  // One SCK period; master samples MISO on the sample edge.
  task automatic clock_bit(input logic tx_bit, output logic rx_a, output logic rx_b);
    MOSI = tx_bit;
    #10;
    SCK = ~CKP;
    if (!CPH) begin rx_a = MISO_a; rx_b = MISO_b; end
    #HALF;
    SCK = CKP;
    if (CPH) begin rx_a = MISO_a; rx_b = MISO_b; end
    #HALF;
  endtask

  // Full CS frame. With ring=1 the master forwards what it receives from B,
  // as a ring-shifting master does.
  task automatic spi_frame(input int nbits, input logic [15:0] tx, input bit ring,
                           output logic [31:0] rxa, output logic [31:0] rxb);
    logic [47:0] sr;
    logic ba, bb;
    sr = {32'd0, tx};
    rxa = '0;
    rxb = '0;
    CS = 1'b0;
    #(HALF * 2);
    for (int i = 0; i < nbits; i++) begin
      clock_bit(sr[i], ba, bb);
      rxa[i] = ba;
      rxb[i] = bb;
      if (ring) sr[i+16] = bb;
    end
    #HALF;
    CS = 1'b1;
    #(HALF * 3);
  endtask

  typedef struct {
    logic        ckp;
    logic        cph;
    logic [15:0] tx;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic [15:0] exp_miso;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin
    logic [31:0] rxa, rxb;
    logic ba, bb;
    int f0, v0;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'hA5C3, 16'h1234, 16'hA5C3};
    vecs[1] = '{1'b0, 1'b1, 16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F};
    vecs[2] = '{1'b1, 1'b0, 16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F};
    vecs[3] = '{1'b1, 1'b1, 16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 16'h0001, 16'h8000, 16'h0001, 16'h8000};

    rst = 1'b0; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    data_in_a = 16'h0000;
    data_in_b = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs A", 64'({MISO_a, data_out_a, data_valid_a, busy_a, frame_err_a}), 64'd0);
    check("reset outputs B", 64'({MISO_b, data_out_b, data_valid_b, busy_b, frame_err_b}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #(HALF * 2);

    // Single frames in all four modes
    for (int k = 0; k < NV; k++) begin
      data_in_a = vecs[k].din;
      set_mode(vecs[k].ckp, vecs[k].cph);
      exp_a.push_back(vecs[k].exp_out);
      exp_b.push_back(vecs[k].exp_miso);
      spi_frame(16, vecs[k].tx, 1'b0, rxa, rxb);
      check($sformatf("vec%0d MISO word", k), 64'(rxa[15:0]), 64'(vecs[k].exp_miso));
      check($sformatf("vec%0d busy idle", k), 64'({busy_a, MISO_a}), 64'd0);
      drain($sformatf("vec%0d", k));
    end

    // Partial frame: CS released after 7 bits
    set_mode(1'b0, 1'b0);
    data_in_a = 16'h5555;
    f0 = ferr_a;
    spi_frame(7, 16'h007F, 1'b0, rxa, rxb);
    check("ferr pulse count", 64'(ferr_a - f0), 64'd1);
    check("ferr data_out held", 64'(data_out_a), 64'(vecs[NV-1].exp_out));
    check("ferr MISO/busy", 64'({MISO_a, busy_a}), 64'd0);
    drain("ferr");

    // Reset in the middle of a frame (during bit 9)
    data_in_a = 16'hAAAA;
    f0 = ferr_a;
    v0 = n_got_a;
    CS = 1'b0;
    #(HALF * 2);
    for (int i = 0; i < 8; i++) clock_bit(1'b1, ba, bb);
    MOSI = 1'b0;
    #10;
    SCK = ~CKP;
    check("busy mid-frame", 64'(busy_a), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid-frame reset A", 64'({MISO_a, data_out_a, data_valid_a, busy_a, frame_err_a}),
          64'd0);
    CS = 1'b1;
    SCK = CKP;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #(HALF * 4);
    check("reset no ferr", 64'(ferr_a - f0), 64'd0);
    check("reset no valid", 64'(n_got_a - v0), 64'd0);
    rd_b = n_got_b;
    data_in_a = 16'h3C3C;
    exp_a.push_back(16'h00FF);
    exp_b.push_back(16'h3C3C);
    spi_frame(16, 16'h00FF, 1'b0, rxa, rxb);
    check("post-reset MISO word", 64'(rxa[15:0]), 64'h3C3C);
    drain("post-reset");

    // SCK activity with CS high is ignored
    for (int i = 0; i < 20; i++) begin
      MOSI = i[0];
      SCK = ~SCK;
      #HALF;
    end
    SCK = CKP;
    #(HALF * 2);
    check("idle SCK MISO/busy", 64'({MISO_a, busy_a}), 64'd0);
    check("idle SCK data_out", 64'(data_out_a), 64'h00FF);
    drain("idle SCK");
    data_in_a = 16'h9669;
    exp_a.push_back(16'h4321);
    exp_b.push_back(16'h9669);
    spi_frame(16, 16'h4321, 1'b0, rxa, rxb);
    check("after idle SCK MISO word", 64'(rxa[15:0]), 64'h9669);
    drain("after idle SCK");

    // Daisy chain, 32 continuous SCKs, ring-shifting master. The ring
    // master->A->B->master rotates by 16 per word: A gets CAFE then B's
    // original word, B gets A's word then CAFE.
    data_in_a = 16'h2222;
    data_in_b = 16'h1111;
    exp_a.push_back(16'hCAFE);
    exp_a.push_back(16'h1111);
    exp_b.push_back(16'h2222);
    exp_b.push_back(16'hCAFE);
    spi_frame(32, 16'hCAFE, 1'b1, rxa, rxb);
    check("chain master word 1", 64'(rxb[15:0]), 64'h1111);
    check("chain master word 2", 64'(rxb[31:16]), 64'h2222);
    drain("chain");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
